// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage, the MEM/WB result buses and the ID/EX stage.
// The master drives ID fields and result buses; the slave (the stage) drives EX outputs.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int FN_W = 5
);
    logic            hold;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_op1_sel, id_op2_sel;
    logic [FN_W-1:0] id_alu_fn;
    logic            id_wb_en, id_mem_read, id_mem_write;
    logic            mem_wb_en;
    logic [RA_W-1:0] mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            wb_wb_en;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall_req;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd;
    logic            ex_wb_en, ex_mem_read, ex_mem_write;
    logic [FN_W-1:0] alu_fn;
    logic [XLEN-1:0] alu_op1, alu_op2;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output hold, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_op1_sel, id_op2_sel, id_alu_fn, id_wb_en, id_mem_read,
               id_mem_write, mem_wb_en, mem_rd, mem_data, wb_wb_en, wb_rd, wb_data,
        input  stall_req, ex_valid, ex_pc, ex_rd, ex_wb_en, ex_mem_read,
               ex_mem_write, alu_fn, alu_op1, alu_op2, ex_store_data
    );

    modport slave (
        input  hold, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data, id_imm,
               id_op1_sel, id_op2_sel, id_alu_fn, id_wb_en, id_mem_read,
               id_mem_write, mem_wb_en, mem_rd, mem_data, wb_wb_en, wb_rd, wb_data,
        output stall_req, ex_valid, ex_pc, ex_rd, ex_wb_en, ex_mem_read,
               ex_mem_write, alu_fn, alu_op1, alu_op2, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and MEM/WB operand forwarding.
// Bubbles and reset share one clear path; ALU operands are selected combinationally.
module id_ex_stage #(
    parameter int              XLEN  = 32,
    parameter int              RA_W  = 5,
    parameter int              FN_W  = 5,
    parameter logic [FN_W-1:0] ALU_X = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    logic            r_valid, r_wb_en, r_mem_read, r_mem_write;
    logic            r_op1_sel, r_op2_sel;
    logic [XLEN-1:0] r_pc, r_imm, r_rs1_data, r_rs2_data;
    logic [RA_W-1:0] r_rd, r_rs1, r_rs2;
    logic [FN_W-1:0] r_alu_fn;

    logic            w_hazard;
    logic [XLEN-1:0] w_cap_rs1, w_cap_rs2;
    logic [XLEN-1:0] w_fwd_rs1, w_fwd_rs2;

    always_comb begin
        w_hazard = r_valid && r_mem_read && (r_rd != '0) && bus.id_valid &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == r_rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == r_rd)));
    end

    assign bus.stall_req = w_hazard && !bus.flush;

    // Register file write in the same cycle as the read would otherwise be lost.
    always_comb begin
        w_cap_rs1 = bus.id_rs1_data;
        w_cap_rs2 = bus.id_rs2_data;
        if (bus.wb_wb_en && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1))
            w_cap_rs1 = bus.wb_data;
        if (bus.wb_wb_en && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2))
            w_cap_rs2 = bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (!bus.hold && (bus.flush || w_hazard))) begin
            r_valid     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_op1_sel   <= 1'b0;
            r_op2_sel   <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_alu_fn    <= ALU_X;
        end else if (!bus.hold) begin
            r_valid     <= bus.id_valid;
            r_wb_en     <= bus.id_wb_en && bus.id_valid;
            r_mem_read  <= bus.id_mem_read && bus.id_valid;
            r_mem_write <= bus.id_mem_write && bus.id_valid;
            r_op1_sel   <= bus.id_op1_sel;
            r_op2_sel   <= bus.id_op2_sel;
            r_pc        <= bus.id_pc;
            r_imm       <= bus.id_imm;
            r_rs1_data  <= w_cap_rs1;
            r_rs2_data  <= w_cap_rs2;
            r_rd        <= bus.id_rd;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_alu_fn    <= bus.id_alu_fn;
        end
    end

    // MEM result is younger than WB, so it wins when both target the same register.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (bus.mem_wb_en && (bus.mem_rd != '0) && (bus.mem_rd == r_rs1))
            w_fwd_rs1 = bus.mem_data;
        else if (bus.wb_wb_en && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1))
            w_fwd_rs1 = bus.wb_data;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (bus.mem_wb_en && (bus.mem_rd != '0) && (bus.mem_rd == r_rs2))
            w_fwd_rs2 = bus.mem_data;
        else if (bus.wb_wb_en && (bus.wb_rd != '0) && (bus.wb_rd == r_rs2))
            w_fwd_rs2 = bus.wb_data;
    end

    assign bus.alu_op1       = r_op1_sel ? r_pc : w_fwd_rs1;
    assign bus.alu_op2       = r_op2_sel ? r_imm : w_fwd_rs2;
    assign bus.ex_store_data = w_fwd_rs2;

    assign bus.ex_valid     = r_valid;
    assign bus.ex_pc        = r_pc;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_wb_en     = r_wb_en;
    assign bus.ex_mem_read  = r_mem_read;
    assign bus.ex_mem_write = r_mem_write;
    assign bus.alu_fn       = r_alu_fn;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic,
// all compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;
    localparam logic [4:0] ALU_X   = 5'h1F;
    localparam logic [4:0] ALU_ADD = 5'h00;

    typedef struct {
        logic        v, wb, mr, mw, s1, s2;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  rd, rs1, rs2, fn;
    } ex_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    ex_t  m;

    id_ex_stage_if #(.XLEN(32), .RA_W(5), .FN_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .RA_W(5), .FN_W(5), .ALU_X(ALU_X)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1, "timeout");
    end

    function automatic ex_t empty_slot();
        ex_t e;
        e.v = 0; e.wb = 0; e.mr = 0; e.mw = 0; e.s1 = 0; e.s2 = 0;
        e.pc = 0; e.imm = 0; e.d1 = 0; e.d2 = 0;
        e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.fn = ALU_X;
        return e;
    endfunction

    // Value of register src as seen now: newest in-flight writer wins, x0 never written.
    function automatic logic [31:0] reg_value(input logic [4:0] src, input logic [31:0] stored);
        if (src == 0) return stored;
        if (bus.mem_wb_en && bus.mem_rd == src) return bus.mem_data;
        if (bus.wb_wb_en && bus.wb_rd == src) return bus.wb_data;
        return stored;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] src, input logic [31:0] rf_data);
        if (src != 0 && bus.wb_wb_en && bus.wb_rd == src) return bus.wb_data;
        return rf_data;
    endfunction

    function automatic bit model_hazard();
        if (!(m.v && m.mr && m.rd != 0 && bus.id_valid)) return 0;
        return (bus.id_use_rs1 && bus.id_rs1 == m.rd) || (bus.id_use_rs2 && bus.id_rs2 == m.rd);
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        if (!rst_n) return empty_slot();
        if (bus.hold) return m;
        if (bus.flush || model_hazard()) return empty_slot();
        n.v = bus.id_valid;
        n.wb = bus.id_wb_en & bus.id_valid;
        n.mr = bus.id_mem_read & bus.id_valid;
        n.mw = bus.id_mem_write & bus.id_valid;
        n.s1 = bus.id_op1_sel; n.s2 = bus.id_op2_sel;
        n.pc = bus.id_pc; n.imm = bus.id_imm;
        n.rd = bus.id_rd; n.rs1 = bus.id_rs1; n.rs2 = bus.id_rs2; n.fn = bus.id_alu_fn;
        n.d1 = rf_read(bus.id_rs1, bus.id_rs1_data);
        n.d2 = rf_read(bus.id_rs2, bus.id_rs2_data);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ex_t n;
        n = model_next();
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic check_all();
        logic [31:0] f1, f2;
        #1;
        f1 = reg_value(m.rs1, m.d1);
        f2 = reg_value(m.rs2, m.d2);
        chk("stall_req", 32'(bus.stall_req), 32'(model_hazard() && !bus.flush));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.v));
        chk("ex_pc", bus.ex_pc, m.pc);
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("ex_wb_en", 32'(bus.ex_wb_en), 32'(m.wb));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
        chk("alu_fn", 32'(bus.alu_fn), 32'(m.fn));
        chk("alu_op1", bus.alu_op1, m.s1 ? m.pc : f1);
        chk("alu_op2", bus.alu_op2, m.s2 ? m.imm : f2);
        chk("ex_store_data", bus.ex_store_data, f2);
    endtask

    task automatic quiet_buses();
        bus.hold = 0; bus.flush = 0;
        bus.mem_wb_en = 0; bus.mem_rd = 0; bus.mem_data = 0;
        bus.wb_wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic s2, input logic mr, input logic mw);
        bus.id_valid = 1; bus.id_pc = pc;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_op1_sel = 0; bus.id_op2_sel = s2; bus.id_alu_fn = ALU_ADD;
        bus.id_wb_en = 1; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic rand_inputs();
        bus.id_valid = ($urandom_range(0, 4) != 0);
        bus.id_pc = $urandom; bus.id_imm = $urandom;
        bus.id_rs1 = 5'($urandom_range(0, 7)); bus.id_rs2 = 5'($urandom_range(0, 7));
        bus.id_rd = 5'($urandom_range(0, 7));
        bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
        bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
        bus.id_op1_sel = 1'($urandom); bus.id_op2_sel = 1'($urandom);
        bus.id_alu_fn = 5'($urandom);
        bus.id_wb_en = 1'($urandom); bus.id_mem_read = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = 1'($urandom);
        bus.mem_wb_en = 1'($urandom); bus.mem_rd = 5'($urandom_range(0, 7)); bus.mem_data = $urandom;
        bus.wb_wb_en = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 7)); bus.wb_data = $urandom;
        bus.hold = ($urandom_range(0, 7) == 0);
        bus.flush = ($urandom_range(0, 5) == 0);
        rst_n = ($urandom_range(0, 39) != 0);
    endtask

    initial begin
        m = empty_slot();
        quiet_buses();
        // Reset with a valid instruction waiting in ID.
        rst_n = 0;
        set_instr(32'h40, 5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd7, 32'd0, 0, 0, 0);
        tick(); tick();
        check_all();
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_alu_fn", 32'(bus.alu_fn), 32'(ALU_X));
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        rst_n = 1;
        tick();
        check_all();
        chk("add_op1", bus.alu_op1, 32'd5);
        chk("add_op2", bus.alu_op2, 32'd7);
        chk("add_rd", 32'(bus.ex_rd), 32'd3);

        // Forward priority on x4.
        set_instr(32'h44, 5'd4, 5'd0, 5'd8, 1, 0, 32'd1, 32'd0, 32'd0, 0, 0, 0);
        tick();
        bus.mem_wb_en = 1; bus.mem_rd = 4; bus.mem_data = 32'hAA;
        bus.wb_wb_en = 1; bus.wb_rd = 4; bus.wb_data = 32'hBB;
        check_all();
        chk("fwd_mem", bus.alu_op1, 32'hAA);
        bus.mem_wb_en = 0;
        check_all();
        chk("fwd_wb", bus.alu_op1, 32'hBB);
        bus.mem_wb_en = 1; bus.mem_rd = 0; bus.wb_wb_en = 0;
        check_all();
        chk("fwd_none", bus.alu_op1, 32'd1);
        quiet_buses();

        // Load-use: LW x5 then ADD x6,x5,x1.
        set_instr(32'h48, 5'd1, 5'd0, 5'd5, 1, 0, 32'd0, 32'd0, 32'd8, 1, 1, 0);
        tick();
        set_instr(32'h4C, 5'd5, 5'd1, 5'd6, 1, 1, 32'd0, 32'd9, 32'd0, 0, 0, 0);
        check_all();
        chk("lu_stall", 32'(bus.stall_req), 32'd1);
        tick();
        check_all();
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        bus.mem_wb_en = 1; bus.mem_rd = 5; bus.mem_data = 32'h1234;
        tick();
        check_all();
        chk("lu_load", 32'(bus.ex_valid), 32'd1);
        chk("lu_op1", bus.alu_op1, 32'h1234);
        chk("lu_one_bubble", 32'(bus.stall_req), 32'd0);
        quiet_buses();

        // Flush beats the hazard.
        set_instr(32'h50, 5'd1, 5'd0, 5'd5, 1, 0, 32'd0, 32'd0, 32'd8, 1, 1, 0);
        tick();
        set_instr(32'h54, 5'd5, 5'd1, 5'd6, 1, 1, 32'd0, 32'd9, 32'd0, 0, 0, 0);
        bus.flush = 1;
        check_all();
        chk("fl_stall", 32'(bus.stall_req), 32'd0);
        tick();
        check_all();
        chk("fl_bubble", 32'(bus.ex_valid), 32'd0);
        quiet_buses();

        // Hold freezes EX while ID keeps changing and flush is asserted.
        set_instr(32'h100, 5'd2, 5'd3, 5'd9, 1, 1, 32'd11, 32'd12, 32'd0, 0, 0, 1);
        tick();
        bus.hold = 1; bus.flush = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(32'h200 + 32'(i * 4), 5'd4, 5'd5, 5'(10 + i), 1, 1, 32'd3, 32'd4, 32'd0, 0, 0, 0);
            tick();
            check_all();
            chk("hold_pc", bus.ex_pc, 32'h100);
            chk("hold_rd", 32'(bus.ex_rd), 32'd9);
        end
        quiet_buses();
        tick();
        check_all();
        chk("hold_release_pc", bus.ex_pc, 32'h208);

        // Capture bypass of a same-cycle register file write.
        set_instr(32'h300, 5'd7, 5'd0, 5'd1, 1, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0);
        bus.wb_wb_en = 1; bus.wb_rd = 7; bus.wb_data = 32'h55;
        tick();
        bus.wb_wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
        check_all();
        chk("cap_op1", bus.alu_op1, 32'h55);

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            check_all();
            tick();
        end
        rst_n = 1;
        quiet_buses();
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
